ram_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the shared single-port RAM. It accepts whole read/write transactions (address plus data) from two independent clients. It serialises each transaction into the RAM's 10-bit command-word protocol, captures read data and returns a one-cycle response to the originating client. It sits between the SPI slave side and any second on-chip master, and it is the only driver of the RAM's `rx_valid`/`din` inputs.

---
 rtl/ram_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter/sequencer turning two clients' read/write requests (req*/rsp*) into RAM 10-bit command words (ram_rx_valid, ram_din) and capturing ram_dout for read responses
module ram_arbiter #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_wr,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [7:0]           req0_wdata,
  output logic                 rsp0_valid,
  output logic [7:0]           rsp0_rdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_wr,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [7:0]           req1_wdata,
  output logic                 rsp1_valid,
  output logic [7:0]           rsp1_rdata,
  output logic                 ram_rx_valid,
  output logic [9:0]           ram_din,
  input  logic [7:0]           ram_dout
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;
  state_t state, state_nx;
  logic last_grant, owner, grant, hs, wr_q, sel_wr;
  logic [7:0] wdata_q, sel_addr, sel_wdata;
  // with a single requester grant follows it; on contention the client not served last wins
  always_comb begin
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    hs         = state == IDLE && !rst && (req0_valid || req1_valid);
    req0_ready = hs && !grant;
    req1_ready = hs && grant;
    sel_wr     = grant ? req1_wr : req0_wr;
    sel_addr   = 8'(grant ? req1_addr : req0_addr);
    sel_wdata  = grant ? req1_wdata : req0_wdata;
    state_nx   = state == IDLE ? (hs ? ADDR : IDLE) :
                 state == ADDR ? DATA :
                 state == DATA ? (wr_q ? IDLE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= 8'h00;
      ram_rx_valid <= 1'b0;
      ram_din      <= 10'h000;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_rdata   <= 8'h00;
      rsp1_rdata   <= 8'h00;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: if (hs) begin
          owner        <= grant;
          last_grant   <= grant;
          wr_q         <= sel_wr;
          wdata_q      <= sel_wdata;
          ram_rx_valid <= 1'b1;
          ram_din      <= {sel_wr ? 2'b00 : 2'b10, sel_addr};
        end
        ADDR: ram_din <= wr_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
        DATA: begin
          ram_rx_valid <= 1'b0;
          ram_din      <= 10'h000;
          rsp0_valid   <= wr_q && !owner;
          rsp1_valid   <= wr_q && owner;
        end
        WAIT: begin
          // the read command was sampled on the previous edge, so ram_dout is current now
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
          if (owner) rsp1_rdata <= ram_dout;
          else       rsp0_rdata <= ram_dout;
        end
      endcase
    end
endmodule
